// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding and the operand-sign predicates.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_RUN    = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic sgnA(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic sgnB(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_rca.sv
// N-bit ripple-carry adder; o_sum[N] is the carry-out.
module MuldivRca #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N:0]   o_sum
);

    logic         w_carry;
    logic [N-1:0] w_bits;

    always_comb begin
        w_carry = i_cin;
        w_bits  = '0;
        for (int k = 0; k < N; k++) begin
            w_bits[k] = i_a[k] ^ i_b[k] ^ w_carry;
            w_carry   = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
        end
        o_sum = {w_carry, w_bits};
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M EX-stage multiply/divide sequencer: one shared ripple-carry adder is
// time-multiplexed across operand negation, XLEN iteration steps and sign fix-up.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] COUNT_LAST = CW'(XLEN - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mq;
    logic [XLEN-1:0] r_b;
    logic [CW-1:0]   r_count;
    logic            r_negA;
    logic            r_negB;
    logic            r_bZero;
    logic            r_carry;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_isDiv;
    logic            w_divAccept;
    logic            w_negLo;
    logic            w_negHi;
    logic            w_retire;
    logic [XLEN-1:0] w_addA;
    logic [XLEN-1:0] w_addB;
    logic            w_addCin;
    logic [XLEN:0]   w_addOut;
    logic [XLEN-1:0] w_accNext;
    logic [XLEN-1:0] w_mqNext;
    logic [XLEN-1:0] w_bNext;
    logic            w_carryNext;
    logic [XLEN-1:0] w_resultSel;

    assign w_accept    = (r_state == ST_IDLE) && i_start && !i_flush;
    assign w_retire    = (r_state == ST_DONE) && !i_flush;
    assign w_isDiv     = is_div(r_op);
    // A restoring step succeeds when the 33-bit partial remainder covers |B|.
    assign w_divAccept = w_addOut[XLEN] | r_acc[XLEN-1];
    // Dividing by zero must leave the all-ones quotient unsigned.
    assign w_negLo     = (r_negA ^ r_negB) & ~(w_isDiv & r_bZero);
    assign w_negHi     = w_isDiv ? r_negA : (r_negA ^ r_negB);

    MuldivRca #(.N(XLEN)) u_rca (
        .i_a   (w_addA),
        .i_b   (w_addB),
        .i_cin (w_addCin),
        .o_sum (w_addOut)
    );

    always_comb begin
        w_nextState = r_state;
        o_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:   if (i_start) w_nextState = ST_NEG_A;
            ST_NEG_A:  w_nextState = ST_NEG_B;
            ST_NEG_B:  w_nextState = ST_RUN;
            ST_RUN:    if (r_count == '0) w_nextState = ST_FIX_LO;
            ST_FIX_LO: w_nextState = ST_FIX_HI;
            ST_FIX_HI: w_nextState = ST_DONE;
            ST_DONE:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
        if (i_flush) w_nextState = ST_IDLE;
    end

    // Negations default to ~mq + 1; other phases override the adder operands.
    always_comb begin
        w_addA   = '0;
        w_addB   = ~r_mq;
        w_addCin = 1'b1;
        case (r_state)
            ST_NEG_B: w_addB = ~r_b;
            ST_RUN: begin
                if (w_isDiv) begin
                    w_addA = {r_acc[XLEN-2:0], r_mq[XLEN-1]};
                    w_addB = ~r_b;
                end else begin
                    w_addA   = r_acc;
                    w_addB   = r_b;
                    w_addCin = 1'b0;
                end
            end
            ST_FIX_HI: begin
                w_addB   = ~r_acc;
                w_addCin = w_isDiv ? 1'b1 : r_carry;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_accNext   = r_acc;
        w_mqNext    = r_mq;
        w_bNext     = r_b;
        w_carryNext = r_carry;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_accNext = '0;
                    w_mqNext  = i_rs1;
                    w_bNext   = i_rs2;
                end
            end
            ST_NEG_A: if (r_negA) w_mqNext = w_addOut[XLEN-1:0];
            ST_NEG_B: if (r_negB) w_bNext = w_addOut[XLEN-1:0];
            ST_RUN: begin
                if (w_isDiv) begin
                    w_accNext = w_divAccept ? w_addOut[XLEN-1:0] : w_addA;
                    w_mqNext  = {r_mq[XLEN-2:0], w_divAccept};
                end else if (r_mq[0]) begin
                    {w_accNext, w_mqNext} = {w_addOut, r_mq[XLEN-1:1]};
                end else begin
                    {w_accNext, w_mqNext} = {1'b0, r_acc, r_mq[XLEN-1:1]};
                end
            end
            ST_FIX_LO: begin
                if (w_negLo) w_mqNext = w_addOut[XLEN-1:0];
                w_carryNext = w_addOut[XLEN];
            end
            ST_FIX_HI: if (w_negHi) w_accNext = w_addOut[XLEN-1:0];
            default: ;
        endcase
    end

    always_comb begin
        w_resultSel = r_acc;
        case (r_op)
            OP_MUL, OP_DIV, OP_DIVU: w_resultSel = r_mq;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_b      <= '0;
            r_count  <= '0;
            r_negA   <= 1'b0;
            r_negB   <= 1'b0;
            r_bZero  <= 1'b0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_nextState;
            r_acc   <= w_accNext;
            r_mq    <= w_mqNext;
            r_b     <= w_bNext;
            r_carry <= w_carryNext;
            r_done  <= w_retire;
            if (w_accept) begin
                r_op    <= i_op;
                r_negA  <= sgnA(i_op) & i_rs1[XLEN-1];
                r_negB  <= sgnB(i_op) & i_rs2[XLEN-1];
                r_bZero <= (i_rs2 == '0);
                r_count <= COUNT_LAST;
            end else if (r_state == ST_RUN) begin
                r_count <= r_count - CW'(1);
            end
            // The result only changes when an operation retires unflushed.
            if (w_retire) r_result <= w_resultSel;
        end
    end

    assign o_done   = r_done;
    assign o_result = r_result;

endmodule
